// File: rtl/key_debounce_multi.sv
//-----------------------------------------------------------------------------
// key_debounce_multi
//
// N-channel push-button conditioner. Each raw key pin is passed through a
// two-flop synchroniser, normalised so that 1 means "pressed", debounced and
// classified by an independent per-channel state machine.
//
// Optional feature macro: KEY_REPEAT_EN
//   When defined, a key held past the long-press point issues an extra
//   key_press pulse every REPEAT_CNT cycles. When undefined, no repeat
//   counter is built and REPEAT_MS has no effect.
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   key          in   [KEY_NUM] raw asynchronous key pins
//   key_value    out  [KEY_NUM] debounced level, 1 = pressed
//   key_press    out  [KEY_NUM] one-cycle pulse per accepted press / repeat
//   key_release  out  [KEY_NUM] one-cycle pulse per accepted release
//   key_long     out  [KEY_NUM] one-cycle pulse when held for LONG_MS
//-----------------------------------------------------------------------------
module key_debounce_multi #(
  parameter int KEY_NUM     = 4,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_value,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int DB_CNT   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CNT = CLK_FREQ / 1000 * LONG_MS;
  localparam int DB_W     = (DB_CNT > 2) ? $clog2(DB_CNT) : 1;
  localparam int LONG_W   = (LONG_CNT > 2) ? $clog2(LONG_CNT) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CNT - 1);
  localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);
  localparam logic [LONG_W-1:0] LONG_ZERO = LONG_W'(0);
  localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

`ifdef KEY_REPEAT_EN
  localparam int REPEAT_CNT = CLK_FREQ / 1000 * REPEAT_MS;
  localparam int REP_W      = (REPEAT_CNT > 2) ? $clog2(REPEAT_CNT) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
  localparam logic [REP_W-1:0] REP_ZERO = REP_W'(0);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  if (REPEAT_CNT < 1) begin : g_bad_repeat
    $error("key_debounce_multi: REPEAT_CNT must be at least 1");
  end
`endif

  // Parameter sanity, rejected at elaboration.
  if ((KEY_NUM < 1) || (KEY_NUM > 16)) begin : g_bad_num
    $error("key_debounce_multi: KEY_NUM must be 1..16");
  end
  if (DB_CNT < 2) begin : g_bad_db
    $error("key_debounce_multi: DB_CNT must be at least 2");
  end
  if (LONG_CNT <= DB_CNT) begin : g_bad_long
    $error("key_debounce_multi: LONG_CNT must exceed DB_CNT");
  end
  if (REPEAT_MS < 0) begin : g_bad_repeat_ms
    $error("key_debounce_multi: REPEAT_MS must not be negative");
  end

  // Released level of the raw pin; the synchroniser resets to it so a
  // reset never looks like a press.
  localparam logic [KEY_NUM-1:0] REL_LEVEL =
    (ACTIVE_LOW != 0) ? {KEY_NUM{1'b1}} : {KEY_NUM{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PDB  = 3'd1,
    ST_HOLD = 3'd2,
    ST_LONG = 3'd3,
    ST_RDB  = 3'd4
  } state_t;

  logic [KEY_NUM-1:0] sync1_r;
  logic [KEY_NUM-1:0] sync2_r;
  logic [KEY_NUM-1:0] pressed_s;

  // Two-flop synchroniser for the asynchronous key pins.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_r <= REL_LEVEL;
      sync2_r <= REL_LEVEL;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
    end
  end

  // Normalise polarity so that 1 always means pressed.
  always_comb begin
    if (ACTIVE_LOW != 0) begin
      pressed_s = ~sync2_r;
    end else begin
      pressed_s = sync2_r;
    end
  end

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    state_t            state_r;
    state_t            state_s;
    logic [DB_W-1:0]   db_cnt_r;
    logic [DB_W-1:0]   db_cnt_s;
    logic [LONG_W-1:0] hold_cnt_r;
    logic [LONG_W-1:0] hold_cnt_s;
    logic              long_flag_r;
    logic              long_flag_s;
    logic              value_r;
    logic              value_s;
    logic              press_r;
    logic              press_s;
    logic              release_r;
    logic              release_s;
    logic              long_r;
    logic              long_s;
`ifdef KEY_REPEAT_EN
    logic [REP_W-1:0]  rep_cnt_r;
    logic [REP_W-1:0]  rep_cnt_s;
`endif

    // Channel state, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state_r     <= ST_IDLE;
        db_cnt_r    <= DB_ZERO;
        hold_cnt_r  <= LONG_ZERO;
        long_flag_r <= 1'b0;
        value_r     <= 1'b0;
        press_r     <= 1'b0;
        release_r   <= 1'b0;
        long_r      <= 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_r   <= REP_ZERO;
`endif
      end else begin
        state_r     <= state_s;
        db_cnt_r    <= db_cnt_s;
        hold_cnt_r  <= hold_cnt_s;
        long_flag_r <= long_flag_s;
        value_r     <= value_s;
        press_r     <= press_s;
        release_r   <= release_s;
        long_r      <= long_s;
`ifdef KEY_REPEAT_EN
        rep_cnt_r   <= rep_cnt_s;
`endif
      end
    end

    // Next-state decode; pulse outputs default low every cycle.
    always_comb begin
      state_s     = state_r;
      db_cnt_s    = db_cnt_r;
      hold_cnt_s  = hold_cnt_r;
      long_flag_s = long_flag_r;
      value_s     = value_r;
      press_s     = 1'b0;
      release_s   = 1'b0;
      long_s      = 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_s   = rep_cnt_r;
`endif
      case (state_r)
        ST_IDLE: begin
          if (pressed_s[g]) begin
            state_s  = ST_PDB;
            db_cnt_s = DB_ZERO;
          end else begin
            state_s  = ST_IDLE;
          end
        end
        ST_PDB: begin
          if (!pressed_s[g]) begin
            state_s = ST_IDLE;
          end else if (db_cnt_r == DB_LAST) begin
            state_s     = ST_HOLD;
            value_s     = 1'b1;
            press_s     = 1'b1;
            hold_cnt_s  = LONG_ZERO;
            long_flag_s = 1'b0;
          end else begin
            db_cnt_s = db_cnt_r + DB_ONE;
          end
        end
        ST_HOLD: begin
          // Release is checked first so it wins over long expiry.
          if (!pressed_s[g]) begin
            state_s  = ST_RDB;
            db_cnt_s = DB_ZERO;
          end else if (hold_cnt_r == LONG_LAST) begin
            state_s     = ST_LONG;
            long_s      = 1'b1;
            long_flag_s = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_cnt_s   = REP_ZERO;
`endif
          end else begin
            hold_cnt_s = hold_cnt_r + LONG_ONE;
          end
        end
        ST_LONG: begin
          if (!pressed_s[g]) begin
            state_s  = ST_RDB;
            db_cnt_s = DB_ZERO;
          end else begin
`ifdef KEY_REPEAT_EN
            if (rep_cnt_r == REP_LAST) begin
              rep_cnt_s = REP_ZERO;
              press_s   = 1'b1;
            end else begin
              rep_cnt_s = rep_cnt_r + REP_ONE;
            end
`else
            state_s = ST_LONG;
`endif
          end
        end
        ST_RDB: begin
          // A bounce back to pressed resumes where the hold left off;
          // hold and repeat counters stay frozen while here.
          if (pressed_s[g]) begin
            if (long_flag_r) begin
              state_s = ST_LONG;
            end else begin
              state_s = ST_HOLD;
            end
          end else if (db_cnt_r == DB_LAST) begin
            state_s   = ST_IDLE;
            value_s   = 1'b0;
            release_s = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_cnt_s = REP_ZERO;
`endif
          end else begin
            db_cnt_s = db_cnt_r + DB_ONE;
          end
        end
        default: begin
          state_s     = ST_IDLE;
          db_cnt_s    = DB_ZERO;
          hold_cnt_s  = LONG_ZERO;
          long_flag_s = 1'b0;
          value_s     = 1'b0;
        end
      endcase
    end

    assign key_value[g]   = value_r;
    assign key_press[g]   = press_r;
    assign key_release[g] = release_r;
    assign key_long[g]    = long_r;
  end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner: synchronises, debounces and classifies each key independently.
- Outputs a stable level plus single-cycle press, release and long-press event pulses.
- Sits between the board key pins and application logic (beep, LED, menu control); replaces per-key single-channel debounce instances.

Parameters:
KEY_NUM, 4, number of independent key channels (1..16)
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
DEBOUNCE_MS, 20, stable time required to accept a level change
LONG_MS, 1000, held time, measured from the press pulse, to flag a long press
REPEAT_MS, 200, auto-repeat period; used only when KEY_REPEAT_EN is defined
ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = raw key reads 1 when pressed

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
key  input  KEY_NUM  raw asynchronous key pins
key_value  output  KEY_NUM  debounced level, normalised: 1 = pressed
key_press  output  KEY_NUM  one-cycle pulse per accepted press (and per repeat)
key_release  output  KEY_NUM  one-cycle pulse per accepted release
key_long  output  KEY_NUM  one-cycle pulse when held for LONG_MS

Behaviour:
- Clock and reset: all flops use sys_clk, with reset sys_rst_n, asynchronous, active-low.
- Derived counts: DB_CNT = CLK_FREQ/1000*DEBOUNCE_MS; LONG_CNT = CLK_FREQ/1000*LONG_MS; REPEAT_CNT = CLK_FREQ/1000*REPEAT_MS.
- Counter widths: $clog2 of the count, minimum 1 bit. Required: DB_CNT >= 2 and LONG_CNT > DB_CNT; elaboration error otherwise.
- Synchroniser: 2-FF per channel; reset value = released level (ACTIVE_LOW ? 1 : 0). "pressed" below means the synchronised bit equals the pressed level.
- Reset values: key_value, key_press, key_release, key_long all 0; every channel FSM in IDLE; all counters 0.
- Per-channel FSM states: IDLE, PDB (press debounce), HOLD, LONG, RDB (release debounce). Plus long_flag bit and counters db_cnt and hold_cnt.
- IDLE: pressed -> PDB, db_cnt = 0.
- PDB:
  - Released -> IDLE, no pulse.
  - Otherwise db_cnt increments.
  - When db_cnt == DB_CNT-1 -> HOLD: key_value = 1, key_press pulse, hold_cnt = 0, long_flag = 0.
- HOLD:
  - hold_cnt increments.
  - hold_cnt == LONG_CNT-1 -> LONG: key_long pulse, long_flag = 1.
  - Released -> RDB, db_cnt = 0. Release takes priority over long expiry in the same cycle.
- LONG: released -> RDB, db_cnt = 0.
- RDB:
  - Pressed -> return to LONG if long_flag, else HOLD; hold_cnt is frozen during RDB and resumes, no pulse.
  - db_cnt reaching DB_CNT-1 -> IDLE: key_value = 0, key_release pulse.
- Latency: a clean raw press arriving before edge k gives key_press high for exactly one cycle after edge k+DB_CNT+2. Release is symmetric for key_release and the key_value fall.
- Channels are fully independent; simultaneous events on several channels, or on several outputs of different channels, in the same cycle are legal.
- At most one of press/release/long pulses per channel per cycle.
- Reset mid-operation: all channels return to IDLE immediately with outputs at 0. A key still held after reset deasserts is reported as a fresh press after debounce.
- Bounce shorter than DB_CNT cycles never changes key_value or produces a pulse.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In LONG, a per-channel repeat counter (reset 0 on entry to LONG) increments.
  - At REPEAT_CNT-1 it wraps to 0 and issues a key_press pulse.
  - Counter freezes in RDB and clears on leaving to IDLE.
- Not defined: no repeat counter is built; LONG only waits for release; REPEAT_MS is ignored.

Test Plan:
Sim parameters for all scenarios: CLK_FREQ=1000, DEBOUNCE_MS=10, LONG_MS=50, REPEAT_MS=20, KEY_NUM=4, ACTIVE_LOW=1 (DB_CNT=10, LONG_CNT=50, REPEAT_CNT=20).
1. Clean press: key[0] 1->0 before edge k, held 30 cycles -> key_press[0] high only after edge k+12; key_value[0]=1 from then on; no key_long.
2. Bounce: key[1] toggles every 3 cycles for 40 cycles, then held 0 -> exactly one key_press[1], 12 cycles after the last toggle; no key_release.
3. Long press: key[2] held 0 for 80 cycles, then released -> key_press, then key_long 50 cycles after it, then one key_release 12 cycles after release; key_value[2] back to 0.
4. Concurrent: key[0] and key[3] pressed on the same edge -> key_press = 4'b1001 in a single cycle; other channels stay 0.
5. Reset mid-hold: assert sys_rst_n low while key[0] is in HOLD, keep key held -> all outputs 0 during reset; after release of reset, key_press[0] fires 12 cycles later.
6. KEY_REPEAT_EN defined, key[1] held 120 cycles -> press pulse, long pulse at +50, repeat press pulses every 20 cycles thereafter; without the macro, no repeat pulses.
